prom_loader: RTL and testbench

PROM_LOADER -- requirements
Module: prom_loader

---
 rtl/prom_loader_pkg.sv | 14 +
 rtl/prom_loader_if.sv | 26 ++
 rtl/prom_loader.sv | 140 ++++++++++++++
 tb/tb_prom_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/prom_loader_pkg.sv
// Shared constants and FSM state type for the PROM frame loader.
package prom_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_LOW,
        S_HIGH,
        S_CHECK
    } state_t;

endpackage

// File: rtl/prom_loader_if.sv
// UART-byte input, PROM write port and status flags of the PROM loader.
interface prom_loader_if #(
    parameter int ROM_WORDS = 4,
    parameter int AW        = $clog2(ROM_WORDS)
);
    logic [7:0]    rx_data_i;
    logic          rx_ready_i;
    logic          rx_ack_o;
    logic          prom_we_o;
    logic [AW-1:0] prom_addr_o;
    logic [15:0]   prom_data_o;
    logic          busy_o;
    logic          done_o;
    logic          error_o;

    // master: byte source / PROM / status observer; slave: the loader
    modport master (
        output rx_data_i, rx_ready_i,
        input  rx_ack_o, prom_we_o, prom_addr_o, prom_data_o, busy_o, done_o, error_o
    );

    modport slave (
        input  rx_data_i, rx_ready_i,
        output rx_ack_o, prom_we_o, prom_addr_o, prom_data_o, busy_o, done_o, error_o
    );
endinterface

// File: rtl/prom_loader.sv
// Parses SYNC/count/words/checksum frames from a UART byte stream into PROM writes.
// Optional inter-byte timeout: define PROM_LOADER_TIMEOUT_EN.
module prom_loader
    import prom_loader_pkg::*;
#(
    parameter int ROM_WORDS      = 4,
    parameter int TIMEOUT_CYCLES = 1250
) (
    input  logic          clk,
    input  logic          reset,
    prom_loader_if.slave  bus
);

    localparam int AW = $clog2(ROM_WORDS);
    localparam int IW = AW + 1;   // index must reach N == ROM_WORDS

    if (ROM_WORDS < 2 || (ROM_WORDS & (ROM_WORDS - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("prom_loader: ROM_WORDS must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
    end

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, n_q, n_d, idx_inc;
    logic [7:0]    sum_q, sum_d, low_q, low_d, sum_next;
    logic          we_q, we_d, done_q, done_d, err_q, err_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   data_q, data_d;

`ifdef PROM_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    assign sum_next = sum_q + bus.rx_data_i;
    assign idx_inc  = idx_q + IW'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        sum_d   = sum_q;
        low_d   = low_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = done_q;
        err_d   = err_q;
`ifdef PROM_LOADER_TIMEOUT_EN
        tmo_d   = '0;
`endif
        if (bus.rx_ready_i) begin
            unique case (state_q)
                S_IDLE: if (bus.rx_data_i == SYNC_BYTE) begin
                    state_d = S_COUNT;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
                S_COUNT: if (bus.rx_data_i == 8'd0 || int'(bus.rx_data_i) > ROM_WORDS) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_LOW;
                    n_d     = IW'(bus.rx_data_i);
                    idx_d   = '0;
                    sum_d   = '0;
                end
                S_LOW: begin
                    low_d   = bus.rx_data_i;
                    sum_d   = sum_next;
                    state_d = S_HIGH;
                end
                S_HIGH: begin
                    sum_d   = sum_next;
                    we_d    = 1'b1;
                    addr_d  = idx_q[AW-1:0];
                    data_d  = {bus.rx_data_i, low_q};
                    idx_d   = idx_inc;
                    state_d = (idx_inc == n_q) ? S_CHECK : S_LOW;
                end
                S_CHECK: begin
                    // checksum is the two's complement of the data-byte sum
                    if (sum_next == 8'h00) done_d = 1'b1;
                    else                   err_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
`ifdef PROM_LOADER_TIMEOUT_EN
        else if (state_q != S_IDLE) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            sum_q   <= '0;
            low_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef PROM_LOADER_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            sum_q   <= sum_d;
            low_q   <= low_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef PROM_LOADER_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign bus.rx_ack_o    = bus.rx_ready_i;
    assign bus.prom_we_o   = we_q;
    assign bus.prom_addr_o = addr_q;
    assign bus.prom_data_o = data_q;
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.done_o      = done_q;
    assign bus.error_o     = err_q;

endmodule

// File: tb/tb_prom_loader.sv
// Random frame stream against a frame-position reference model, plus literal frame checks.
module tb_prom_loader;
    import prom_loader_pkg::*;

    localparam int RW  = 4;
    localparam int AW  = $clog2(RW);
    localparam int TMO = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    prom_loader_if #(.ROM_WORDS(RW)) bus();
    prom_loader #(.ROM_WORDS(RW), .TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Reference model: position within the current frame (-1 = hunting for SYNC)
    int            m_pos = -1;
    int            m_n = 0;
    logic [7:0]    m_sum = 0, m_low = 0, m_b = 0;
    logic          m_we = 0, m_busy = 0, m_done = 0, m_err = 0;
    logic [AW-1:0] m_addr = 0;
    logic [15:0]   m_data = 0;
`ifdef PROM_LOADER_TIMEOUT_EN
    int            m_tmo = 0;
`endif

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pos = -1; m_n = 0; m_sum = 0; m_low = 0;
            m_we = 0; m_busy = 0; m_done = 0; m_err = 0; m_addr = 0; m_data = 0;
`ifdef PROM_LOADER_TIMEOUT_EN
            m_tmo = 0;
`endif
        end else begin
            m_we = 0;
            if (bus.rx_ready_i) begin
                m_b = bus.rx_data_i;
`ifdef PROM_LOADER_TIMEOUT_EN
                m_tmo = 0;
`endif
                if (m_pos < 0) begin
                    if (m_b == 8'hA5) begin
                        m_pos = 0; m_busy = 1; m_done = 0; m_err = 0;
                    end
                end else if (m_pos == 0) begin
                    if (m_b == 0 || int'(m_b) > RW) begin
                        m_pos = -1; m_busy = 0; m_err = 1;
                    end else begin
                        m_n = int'(m_b); m_sum = 0; m_pos = 1;
                    end
                end else if (m_pos <= 2 * m_n) begin
                    m_sum = m_sum + m_b;
                    if ((m_pos - 1) % 2 == 0) m_low = m_b;
                    else begin
                        m_we = 1;
                        m_addr = AW'((m_pos - 1) / 2);
                        m_data = {m_b, m_low};
                    end
                    m_pos++;
                end else begin
                    if (8'(m_sum + m_b) == 8'h00) m_done = 1;
                    else                         m_err = 1;
                    m_pos = -1; m_busy = 0;
                end
            end
`ifdef PROM_LOADER_TIMEOUT_EN
            else if (m_busy) begin
                m_tmo++;
                if (m_tmo == TMO) begin
                    m_pos = -1; m_busy = 0; m_err = 1; m_tmo = 0;
                end
            end else m_tmo = 0;
`endif
        end
    end

    logic [15:0] mem [RW];
    int strobes = 0;

    always @(negedge clk) begin
        chk("ack", bus.rx_ack_o, bus.rx_ready_i);
        chk("we", bus.prom_we_o, m_we);
        if (m_we) begin
            chk("addr", bus.prom_addr_o, m_addr);
            chk("data", bus.prom_data_o, m_data);
        end
        chk("busy", bus.busy_o, m_busy);
        chk("done", bus.done_o, m_done);
        chk("error", bus.error_o, m_err);
        if (bus.prom_we_o) begin
            mem[bus.prom_addr_o] = bus.prom_data_o;
            strobes++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data_i  = b;
        bus.rx_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.rx_ready_i = 1'b0;
    endtask

    logic [7:0] fq[$];

    task automatic send_fq(input int upto);
        for (int i = 0; i < upto; i++) begin
            send(fq[i]);
            idle($urandom_range(0, 3));
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
    endtask

    int s0;
    logic [7:0] sum, b;
    int n;

    initial begin
        bus.rx_data_i  = 8'h00;
        bus.rx_ready_i = 1'b0;
        #1 reset = 1'b1;
        idle(2);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_we", bus.prom_we_o, 0);
        chk("rst_done_err", {bus.done_o, bus.error_o}, 0);
        reset = 1'b0;
        idle(1);

        // good two-word frame: checksum EC makes the data-byte sum wrap to zero
        s0 = strobes;
        fq = '{8'hA5, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'hEC};
        send_fq(fq.size()); idle(2);
        chk("f1_mem0", mem[0], 16'h1234);
        chk("f1_mem1", mem[1], 16'h5678);
        chk("f1_strobes", strobes - s0, 2);
        chk("f1_done", bus.done_o, 1);
        chk("f1_err", bus.error_o, 0);

        // same frame, bad checksum: words stay written, error flagged
        s0 = strobes;
        mem[0] = 16'h0; mem[1] = 16'h0;
        fq = '{8'hA5, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h09};
        send_fq(fq.size()); idle(2);
        chk("f2_strobes", strobes - s0, 2);
        chk("f2_mem1", mem[1], 16'h5678);
        chk("f2_done_err", {bus.done_o, bus.error_o}, 2'b01);

        // count larger than PROM depth
        s0 = strobes;
        fq = '{8'hA5, 8'h05};
        send_fq(fq.size()); idle(2);
        chk("f3_strobes", strobes - s0, 0);
        chk("f3_err", bus.error_o, 1);
        chk("f3_busy", bus.busy_o, 0);

        // leading garbage ignored, single word
        fq = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'hCD, 8'hAB, 8'h88};
        send_fq(fq.size()); idle(2);
        chk("f4_mem0", mem[0], 16'hABCD);
        chk("f4_done_err", {bus.done_o, bus.error_o}, 2'b10);

        // reset mid-frame, after word 0 has been written
        fq = '{8'hA5, 8'h02, 8'h34, 8'h12};
        send_fq(fq.size()); idle(2);
        s0 = strobes;
        pulse_reset();
        idle(3);
        chk("f5_strobes", strobes - s0, 0);
        chk("f5_busy", bus.busy_o, 0);
        fq = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'hCD};
        send_fq(fq.size()); idle(2);
        chk("f5_mem0", mem[0], 16'h2211);
        chk("f5_done", bus.done_o, 1);

`ifdef PROM_LOADER_TIMEOUT_EN
        send(8'hA5); send(8'h01);
        idle(TMO);
        chk("tmo_err", bus.error_o, 1);
        chk("tmo_busy", bus.busy_o, 0);
        send(8'h34); idle(1);
        chk("tmo_ignored", bus.busy_o, 0);
`endif

        // random frames, some invalid, some with bad checksums, some cut by reset
        for (int it = 0; it < 150; it++) begin
            fq.delete();
            repeat ($urandom_range(0, 2)) begin
                do b = 8'($urandom); while (b == 8'hA5);
                fq.push_back(b);
            end
            fq.push_back(8'hA5);
            n = (($urandom_range(0, 9)) == 0) ? $urandom_range(5, 255) * ($urandom_range(0, 1)) : $urandom_range(1, RW);
            fq.push_back(8'(n));
            if (n >= 1 && n <= RW) begin
                sum = 0;
                for (int k = 0; k < 2 * n; k++) begin
                    b = 8'($urandom);
                    sum = sum + b;
                    fq.push_back(b);
                end
                fq.push_back(($urandom_range(0, 3) != 0) ? 8'(-sum) : 8'($urandom));
            end
            if (it % 17 == 5) begin
                send_fq($urandom_range(1, fq.size() - 1));
                pulse_reset();
            end else begin
                send_fq(fq.size());
            end
            idle(1);
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
